// File: rtl/rotation_amount_finder.sv
// rotation_amount_finder
//   Sequential inverse of the combinational rotator. Given an original word
//   and a rotated word, it finds the smallest rotation amount in the selected
//   direction that maps the original onto the rotated word. One candidate
//   amount is tested per clock.
//
// Ports
//   clk     : clock, rising edge
//   rst_n   : asynchronous active-low reset
//   start   : request a search (sampled only while idle)
//   a       : original word, sampled with start
//   y       : rotated word, sampled with start
//   rsh     : 1 = find left-rotation amount, 0 = find right-rotation amount
//   busy    : high while searching
//   done    : one-cycle pulse when the result is valid
//   found   : last search succeeded
//   shifts  : last rotation amount found (0 when found = 0)
module rotation_amount_finder #(
   parameter  int WIDTH = 8,
   localparam int CW    = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] y,
   input  logic             rsh,
   output logic             busy,
   output logic             done,
   output logic             found,
   output logic [CW-1:0]    shifts
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SEARCH = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] cand_q;
   logic [WIDTH-1:0] tgt_q;
   logic             dir_q;
   logic [CW-1:0]    k_q;
   logic             found_q;
   logic [CW-1:0]    shifts_q;

   // Candidate advanced by one position in the latched direction.
   logic [WIDTH-1:0] cand_d;
   logic             last_k;

   always_comb begin
      if (dir_q)
         cand_d = {cand_q[WIDTH-2:0], cand_q[WIDTH-1]};
      else
         cand_d = {cand_q[0], cand_q[WIDTH-1:1]};
   end

   // The last amount is tested before giving up, so k never wraps.
   assign last_k = (k_q == CW'(WIDTH - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         cand_q   <= '0;
         tgt_q    <= '0;
         dir_q    <= 1'b0;
         k_q      <= '0;
         found_q  <= 1'b0;
         shifts_q <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  cand_q  <= a;
                  tgt_q   <= y;
                  dir_q   <= rsh;
                  k_q     <= '0;
                  state_q <= S_SEARCH;
               end
            end
            S_SEARCH: begin
               // Testing amounts in increasing order makes the first hit
               // the smallest matching amount.
               if (cand_q == tgt_q) begin
                  found_q  <= 1'b1;
                  shifts_q <= k_q;
                  state_q  <= S_DONE;
               end else if (last_k) begin
                  found_q  <= 1'b0;
                  shifts_q <= '0;
                  state_q  <= S_DONE;
               end else begin
                  cand_q <= cand_d;
                  k_q    <= k_q + 1'b1;
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign busy   = (state_q == S_SEARCH);
   assign done   = (state_q == S_DONE);
   assign found  = found_q;
   assign shifts = shifts_q;

endmodule

// File: tb/tb_rotation_amount_finder.sv
// Testbench for rotation_amount_finder: directed cases plus randomized
// searches checked against a reference model that computes rotations by
// plain shift arithmetic and scans for the smallest matching amount.
module tb_rotation_amount_finder;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [7:0] a;
   logic [7:0] y;
   logic       rsh;
   logic       busy;
   logic       done;
   logic       found;
   logic [2:0] shifts;

   int vectors;
   int miscompares;

   rotation_amount_finder #(.WIDTH(8)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .a      (a),
      .y      (y),
      .rsh    (rsh),
      .busy   (busy),
      .done   (done),
      .found  (found),
      .shifts (shifts)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] rot(input logic [7:0] v, input int n, input bit left);
      logic [15:0] w;
      w = {8'h00, v};
      if (left)
         rot = 8'((w << n) | (w >> (8 - n)));
      else
         rot = 8'((w >> n) | (w << (8 - n)));
   endfunction

   // Smallest amount m in 0..7 with rot(a, m) == y.
   task automatic model(input logic [7:0] ma, input logic [7:0] my, input bit left,
                        output bit mf, output int ms);
      mf = 1'b0;
      ms = 0;
      for (int m = 0; m < 8; m++) begin
         if (!mf && rot(ma, m, left) == my) begin
            mf = 1'b1;
            ms = m;
         end
      end
   endtask

   task automatic run(input logic [7:0] ta, input logic [7:0] ty, input bit trsh,
                      input bit glitch);
      bit         ef;
      int         es;
      int         cnt;
      int         n;
      bit         done_seen;
      logic       prev_f;
      logic [2:0] prev_s;
      model(ta, ty, trsh, ef, es);
      prev_f = found;
      prev_s = shifts;
      a = ta; y = ty; rsh = trsh; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      a = 8'($urandom); y = 8'($urandom); rsh = 1'($urandom);
      chk("busy_rise", busy, 1);
      chk("found_held", found, prev_f);
      chk("shifts_held", shifts, prev_s);
      cnt = 0; n = 0; done_seen = 1'b0;
      while (n < 40 && !done_seen) begin
         if (done) begin
            done_seen = 1'b1;
         end else begin
            if (busy) cnt++;
            if (glitch && cnt == 2) begin
               start = 1'b1;
               a = 8'($urandom); y = 8'($urandom); rsh = 1'($urandom);
            end else begin
               start = 1'b0;
            end
            @(posedge clk); #1;
            n++;
         end
      end
      start = 1'b0;
      chk("done_seen", done_seen, 1);
      chk("busy_at_done", busy, 0);
      chk("busy_cycles", cnt, ef ? es + 1 : 8);
      chk("found", found, ef);
      chk("shifts", shifts, es);
      $display("search a=%02h y=%02h rsh=%0d -> found=%0d shifts=%0d busy_cycles=%0d",
               ta, ty, trsh, found, shifts, cnt);
      @(posedge clk); #1;
      chk("done_pulse", done, 0);
      chk("idle_busy", busy, 0);
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      start = 1'b0; a = 8'h00; y = 8'h00; rsh = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_found", found, 0);
      chk("rst_shifts", shifts, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      run(8'h81, 8'h03, 1'b1, 1'b0);
      run(8'h81, 8'hC0, 1'b0, 1'b0);
      run(8'h81, 8'hC0, 1'b1, 1'b0);
      run(8'h01, 8'h03, 1'b0, 1'b0);
      run(8'h01, 8'h03, 1'b1, 1'b0);
      run(8'h5A, 8'h5A, 1'b0, 1'b0);
      run(8'hAA, 8'h55, 1'b1, 1'b0);
      run(8'h00, 8'h00, 1'b1, 1'b0);
      run(8'hFF, 8'hFF, 1'b0, 1'b0);
      run(8'h12, 8'h21, 1'b1, 1'b0);
      run(8'h01, 8'h80, 1'b1, 1'b1);
      run(8'h03, 8'h60, 1'b0, 1'b1);

      // Reset in the 4th search cycle aborts with no done pulse.
      a = 8'h01; y = 8'h80; rsh = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      chk("pre_abort_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_found", found, 0);
      chk("abort_shifts", shifts, 0);
      begin
         bit saw_done;
         saw_done = 1'b0;
         for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (done) saw_done = 1'b1;
         end
         @(negedge clk);
         rst_n = 1'b1;
         for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (done || busy) saw_done = 1'b1;
         end
         chk("abort_no_done", saw_done, 0);
      end
      run(8'h01, 8'h80, 1'b1, 1'b0);

      for (int i = 0; i < 40; i++) begin
         logic [7:0] ra;
         logic [7:0] ry;
         bit         rd;
         ra = 8'($urandom);
         rd = 1'($urandom);
         if ($urandom_range(0, 3) != 0)
            ry = rot(ra, int'($urandom_range(0, 7)), bit'($urandom_range(0, 1)));
         else
            ry = 8'($urandom);
         run(ra, ry, rd, bit'($urandom_range(0, 3) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/rotation_amount_finder.md
# rotation_amount_finder

Sequential inverse of the team's combinational 8-bit rotator: given an original word and a rotated word, it finds the smallest rotation amount, in a selected direction, that maps one onto the other. It tests one candidate amount per clock. It sits beside the rotator in datapath self-check and decode logic, where a rotated operand must be traced back to its shift count. Control uses a start/busy/done handshake.

## Interface
- `WIDTH`, default 8: data width in bits. Must be a power of two, ≥ 2.
- `CW`, default `$clog2(WIDTH)`: width of the shift-amount output. Derived; not overridden.

- `clk`  input  1  single clock; all state changes on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `start`  input  1  request a search; sampled only in IDLE.
- `a`  input  WIDTH  original word; sampled with `start`.
- `y`  input  WIDTH  rotated word; sampled with `start`.
- `rsh`  input  1  direction; sampled with `start`. 1 = find left-rotation amount, 0 = find right-rotation amount.
- `busy`  output  1  high while searching.
- `done`  output  1  one-cycle pulse when a result is valid.
- `found`  output  1  last search succeeded.
- `shifts`  output  CW  last rotation amount found; 0 when `found`=0.

## Operation
- States: IDLE, SEARCH, DONE.
- Internal registers:
  - `cand` (WIDTH): candidate word.
  - `tgt` (WIDTH): latched `y`.
  - `dir` (1): latched `rsh`.
  - `k` (CW): candidate amount.
- IDLE:
  - If `start`=1: `cand`←`a`, `tgt`←`y`, `dir`←`rsh`, `k`←0; go to SEARCH.
  - Otherwise stay in IDLE.
- SEARCH, evaluated every cycle:
  - If `cand`==`tgt`: `shifts`←`k`, `found`←1; go to DONE.
  - Else if `k`==WIDTH-1: `shifts`←0, `found`←0; go to DONE.
  - Else: rotate `cand` by one position (left if `dir`=1, right if `dir`=0), `k`←`k`+1; stay in SEARCH.
- DONE: lasts exactly one cycle, then returns to IDLE. `start` is ignored in DONE.
- `start` is ignored while in SEARCH. Inputs `a`, `y` and `rsh` may change freely after the start cycle.
- `found` and `shifts` hold their value from the last completed search until the next DONE. They do not change at start.
- The smallest matching amount always wins:
  - `a`==`y` gives 0.
  - All-zeros or all-ones words give 0.
  - Periodic patterns (e.g. 0xAA) give the smallest period match.
- Rotation is pure rotation, with no fill bits. `k` never wraps: the search terminates at WIDTH-1.

## Timing
- Reset (asynchronous, immediate on `rst_n`=0):
  - State → IDLE.
  - `busy`=0, `done`=0, `found`=0, `shifts`=0.
  - `cand`, `tgt`, `dir`, `k` cleared.
- Reset asserted mid-search aborts the search. No `done` pulse is produced. On release the block is in IDLE.
- Outputs are registered or decoded from state:
  - `busy` = (state==SEARCH).
  - `done` = (state==DONE).
- For `start` sampled at edge E0:
  - `busy` rises after E0.
  - Match at amount m: `busy` is high for m+1 cycles. `done` is high in the cycle after `busy` falls, with `found`/`shifts` already valid.
  - No match: `busy` is high for WIDTH cycles (8 by default), then `done` with `found`=0.
  - Start-to-done latency: m+2 edges for a match; WIDTH+1 edges for no match.
- Back-to-back: the earliest next accepted `start` is the cycle after `done`. Minimum issue interval is m+3 cycles.

## Test plan
- Reset, then `a`=0x81, `y`=0x03, `rsh`=1, `start` for 1 cycle -> `busy` for 2 cycles, then `done`=1, `found`=1, `shifts`=1.
- `a`=0x81, `y`=0xC0, `rsh`=0 -> `found`=1, `shifts`=1. Repeat with `rsh`=1 -> `shifts`=7, `busy` high for 8 cycles.
- `a`=0x01, `y`=0x03, either direction -> `busy` for 8 cycles, then `done`, `found`=0, `shifts`=0. Prior result is replaced only at `done`.
- Edge values:
  - `a`=`y`=0x5A -> `shifts`=0, `done` 2 edges after start.
  - `a`=0xAA, `y`=0x55, `rsh`=1 -> `shifts`=1.
- Pulse `start` again mid-search with different `a`/`y` -> ignored; the result matches the first request.
- Assert `rst_n`=0 in the 4th SEARCH cycle (`a`=0x01, `y`=0x80, `rsh`=1) -> all outputs 0 immediately, no `done` pulse. A new search after release completes normally with `shifts`=7.
